// File: rtl/otp_lc_prog_rsp.sv
// otp_lc_prog_rsp: single-outstanding OTP macro model with OR-only programming and fixed response latency
module otp_lc_prog_rsp #(
  parameter int NumWords   = 16,
  parameter int BaseAddr   = 0,
  parameter int RspLatency = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        otp_req_i,
  input  logic [2:0]  otp_cmd_i,
  input  logic [1:0]  otp_size_i,
  input  logic [63:0] otp_wdata_i,
  input  logic [10:0] otp_addr_i,
  output logic        otp_gnt_o,
  output logic        otp_rvalid_o,
  output logic [63:0] otp_rdata_o,
  output logic [2:0]  otp_err_o,
  output logic        idle_o
);
  localparam int IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [10:0] Base = 11'(BaseAddr);
  localparam logic [3:0] CntInit = 4'(RspLatency - 1);
  localparam logic [2:0] NoError = 3'd0;
  localparam logic [2:0] MacroError = 3'd1;
  localparam logic [2:0] MacroWriteBlankError = 3'd4;
  // Pairwise Hamming distance >= 3 so a single flipped bit never lands on a legal state
  typedef enum logic [4:0] {
    IdleSt = 5'b00111,
    WaitSt = 5'b11100,
    RspSt  = 5'b01001
  } state_e;
  logic [4:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic fsm_err_q, fsm_err_d;
  logic [2:0] cmd_q;
  logic [1:0] size_q;
  logic [10:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] mem_q [NumWords];
  logic [10:0] idx;
  logic [IdxW-1:0] widx;
  logic [15:0] cur;
  logic in_win, is_rd, is_wr, bad, rsp, accept, blank_err;
  logic unused_wdata;
  assign unused_wdata = ^otp_wdata_i[63:16];
  assign idx = addr_q - Base;
  assign widx = idx[IdxW-1:0];
  assign in_win = idx < 11'(NumWords);
  assign cur = in_win ? mem_q[widx] : '0;
  assign is_rd = cmd_q == 3'd0;
  assign is_wr = cmd_q == 3'd1;
  assign bad = fsm_err_q | ~(is_rd | is_wr) | (size_q != 2'd0) | ~in_win;
  assign blank_err = is_wr & (|(cur & ~wdata_q));
  assign rsp = state_q == RspSt;
  assign idle_o = state_q == IdleSt;
  assign accept = idle_o & otp_req_i;
  assign otp_gnt_o = accept;
  assign otp_rvalid_o = rsp;
  assign otp_rdata_o = (rsp && !bad && is_rd) ? {48'b0, cur} : '0;
  assign otp_err_o = !rsp ? NoError : bad ? MacroError : blank_err ? MacroWriteBlankError : NoError;
  always_comb begin
    state_d = IdleSt;
    cnt_d = cnt_q;
    fsm_err_d = fsm_err_q;
    case (state_q)
      IdleSt: begin
        state_d = accept ? ((RspLatency == 1) ? RspSt : WaitSt) : IdleSt;
        cnt_d = accept ? CntInit : 4'd0;
      end
      WaitSt: begin
        state_d = (cnt_q <= 4'd1) ? RspSt : WaitSt;
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      end
      RspSt: fsm_err_d = 1'b0;
      default: fsm_err_d = 1'b1;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IdleSt;
      cnt_q <= '0;
      fsm_err_q <= 1'b0;
      cmd_q <= '0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fsm_err_q <= fsm_err_d;
      if (accept) begin
        cmd_q <= otp_cmd_i;
        size_q <= otp_size_i;
        addr_q <= otp_addr_i;
        wdata_q <= otp_wdata_i[15:0];
      end
    end
  end
  // OR-in only: programmed bits can never be cleared except by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else if (rsp && !bad && is_wr) begin
      mem_q[widx] <= cur | wdata_q;
    end
  end
endmodule

// File: tb/tb_otp_lc_prog_rsp.sv
// tb_otp_lc_prog_rsp: directed table plus multi-cycle sequences for otp_lc_prog_rsp
module tb_otp_lc_prog_rsp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req0 = 1'b0, req1 = 1'b0, req4 = 1'b0;
  logic [2:0] cmd = '0;
  logic [1:0] size = '0;
  logic [63:0] wdata = '0;
  logic [10:0] addr = '0;
  logic g0, v0, i0, g1, v1, i1, g4, v4, i4;
  logic [63:0] rd0, rd1, rd4;
  logic [2:0] er0, er1, er4;

  otp_lc_prog_rsp #(.NumWords(16), .BaseAddr(8), .RspLatency(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .otp_req_i(req0), .otp_cmd_i(cmd), .otp_size_i(size),
    .otp_wdata_i(wdata), .otp_addr_i(addr), .otp_gnt_o(g0), .otp_rvalid_o(v0),
    .otp_rdata_o(rd0), .otp_err_o(er0), .idle_o(i0));
  otp_lc_prog_rsp #(.NumWords(16), .BaseAddr(0), .RspLatency(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .otp_req_i(req1), .otp_cmd_i(cmd), .otp_size_i(size),
    .otp_wdata_i(wdata), .otp_addr_i(addr), .otp_gnt_o(g1), .otp_rvalid_o(v1),
    .otp_rdata_o(rd1), .otp_err_o(er1), .idle_o(i1));
  otp_lc_prog_rsp #(.NumWords(16), .BaseAddr(0), .RspLatency(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .otp_req_i(req4), .otp_cmd_i(cmd), .otp_size_i(size),
    .otp_wdata_i(wdata), .otp_addr_i(addr), .otp_gnt_o(g4), .otp_rvalid_o(v4),
    .otp_rdata_o(rd4), .otp_err_o(er4), .idle_o(i4));

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] cmd;
    logic [1:0] size;
    logic [10:0] addr;
    logic [15:0] wd;
    logic [63:0] rd;
    logic [2:0] er;
  } vec_t;
  vec_t tbl[17];

  task automatic run(input logic [2:0] c, input logic [1:0] s, input logic [10:0] a,
                     input logic [15:0] w, output logic [63:0] rd, output logic [2:0] er,
                     output int lat, output bit quiet);
    int n;
    @(negedge clk);
    cmd = c; size = s; addr = a; wdata = {48'hDEADBEEFCAFE, w}; req0 = 1'b1;
    #1;
    n = 0;
    while (!g0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!g0) chk("grant_timeout", 64'(g0), 64'd1);
    @(negedge clk);
    req0 = 1'b0; cmd = 3'd5; size = 2'd3; addr = 11'h7FF; wdata = '1;
    lat = 1;
    quiet = 1'b1;
    while (!v0 && lat < 20) begin
      if (rd0 != 0 || er0 != 0) quiet = 1'b0;
      @(negedge clk);
      lat++;
    end
    rd = rd0;
    er = er0;
    @(negedge clk);
    if (rd0 != 0 || er0 != 0 || v0) quiet = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    logic [2:0] er;
    int lat, ng1, ng4, nv1, nv4, last1, last4, bad1, bad4, gi, rv;
    bit q;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(g0), 64'd0);
    chk("rst_rvalid", 64'(v0), 64'd0);
    chk("rst_rdata", rd0, 64'd0);
    chk("rst_err", 64'(er0), 64'd0);
    chk("rst_idle", 64'({i0, i1, i4}), 64'h7);
    rst_n = 1'b1;
    tbl[0]  = '{3'd1, 2'd0, 11'd11, 16'h00F0, 64'h0,    3'd0};
    tbl[1]  = '{3'd0, 2'd0, 11'd11, 16'h0000, 64'h00F0, 3'd0};
    tbl[2]  = '{3'd1, 2'd0, 11'd11, 16'h000F, 64'h0,    3'd4};
    tbl[3]  = '{3'd0, 2'd0, 11'd11, 16'h0000, 64'h00FF, 3'd0};
    tbl[4]  = '{3'd0, 2'd0, 11'd24, 16'h0000, 64'h0,    3'd1};
    tbl[5]  = '{3'd0, 2'd1, 11'd11, 16'h0000, 64'h0,    3'd1};
    tbl[6]  = '{3'd2, 2'd0, 11'd11, 16'hFFFF, 64'h0,    3'd1};
    tbl[7]  = '{3'd0, 2'd0, 11'd11, 16'h0000, 64'h00FF, 3'd0};
    tbl[8]  = '{3'd1, 2'd0, 11'd7,  16'hFFFF, 64'h0,    3'd1};
    tbl[9]  = '{3'd0, 2'd0, 11'd8,  16'h0000, 64'h0,    3'd0};
    tbl[10] = '{3'd1, 2'd0, 11'd23, 16'h8001, 64'h0,    3'd0};
    tbl[11] = '{3'd0, 2'd0, 11'd23, 16'h0000, 64'h8001, 3'd0};
    tbl[12] = '{3'd1, 2'd0, 11'd23, 16'h8003, 64'h0,    3'd0};
    tbl[13] = '{3'd0, 2'd0, 11'd23, 16'h0000, 64'h8003, 3'd0};
    tbl[14] = '{3'd1, 2'd0, 11'd11, 16'hFFFF, 64'h0,    3'd0};
    tbl[15] = '{3'd0, 2'd0, 11'd11, 16'h0000, 64'hFFFF, 3'd0};
    tbl[16] = '{3'd7, 2'd0, 11'd11, 16'h0000, 64'h0,    3'd1};
    for (int i = 0; i < 17; i++) begin
      run(tbl[i].cmd, tbl[i].size, tbl[i].addr, tbl[i].wd, rd, er, lat, q);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(tbl[i].er));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_quiet", i), 64'(q), 64'd1);
    end
    // Back-to-back writes with req held high on the latency-1 and latency-4 instances
    ng1 = 0; ng4 = 0; nv1 = 0; nv4 = 0; last1 = -1; last4 = -1; bad1 = 0; bad4 = 0; gi = 0;
    @(negedge clk);
    cmd = 3'd1; size = 2'd0; addr = 11'd5; wdata = 64'h1; req1 = 1'b1; req4 = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (g1 && !i1) gi++;
      if (g4 && !i4) gi++;
      if (v1) nv1++;
      if (v4) nv4++;
      if (g1) begin
        if (last1 >= 0 && cyc - last1 != 2) bad1++;
        last1 = cyc;
        ng1++;
      end
      if (g4) begin
        if (last4 >= 0 && cyc - last4 != 5) bad4++;
        last4 = cyc;
        ng4++;
      end
      @(negedge clk);
      if (ng1 >= 3) req1 = 1'b0;
      if (ng4 >= 3) req4 = 1'b0;
    end
    chk("b2b_grants_l1", 64'(ng1), 64'd3);
    chk("b2b_rvalids_l1", 64'(nv1), 64'd3);
    chk("b2b_spacing_l1", 64'(bad1), 64'd0);
    chk("b2b_grants_l4", 64'(ng4), 64'd3);
    chk("b2b_rvalids_l4", 64'(nv4), 64'd3);
    chk("b2b_spacing_l4", 64'(bad4), 64'd0);
    chk("b2b_gnt_outside_idle", 64'(gi), 64'd0);
    // Illegal state value recovers to idle and poisons the next response only
    @(negedge clk);
    force dut0.state_q = 5'b11111;
    #1 chk("illegal_not_idle", 64'(i0), 64'd0);
    @(negedge clk);
    release dut0.state_q;
    @(negedge clk);
    #1 chk("illegal_recover_idle", 64'(i0), 64'd1);
    run(3'd0, 2'd0, 11'd11, 16'h0, rd, er, lat, q);
    chk("illegal_rsp_err", 64'(er), 64'd1);
    chk("illegal_rsp_rdata", rd, 64'd0);
    run(3'd0, 2'd0, 11'd11, 16'h0, rd, er, lat, q);
    chk("post_illegal_err", 64'(er), 64'd0);
    chk("post_illegal_rdata", rd, 64'hFFFF);
    // Reset during WaitSt of a write aborts it
    @(negedge clk);
    cmd = 3'd1; size = 2'd0; addr = 11'd12; wdata = 64'h1234; req0 = 1'b1;
    #1 chk("rst_mid_gnt", 64'(g0), 64'd1);
    @(negedge clk);
    req0 = 1'b0;
    #1 chk("rst_mid_waitst", 64'(i0), 64'd0);
    rst_n = 1'b0;
    #1 chk("rst_mid_idle", 64'(i0), 64'd1);
    rv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (v0) rv++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (v0) rv++;
    end
    chk("rst_mid_no_rvalid", 64'(rv), 64'd0);
    run(3'd0, 2'd0, 11'd12, 16'h0, rd, er, lat, q);
    chk("rst_mid_read_rdata", rd, 64'd0);
    chk("rst_mid_read_err", 64'(er), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
